// File: rtl/clk_lock_rst_seq.sv
// PLL-lock driven reset sequencer: synchronizes LOCK, qualifies it for STABLE_CYCLES,
// filters lock loss, and drives a registered active-low system reset with READY.
module clk_lock_rst_seq #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 1024,
    parameter int LOSS_FILTER   = 4,
    parameter int HOLD_CYCLES   = 16
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       LOCK,
    input  logic       SW_RST_REQ,
    output logic       SYS_RESET_N,
    output logic       READY,
    output logic [7:0] LOCK_LOST_CNT,
    output logic [1:0] STATE
);

    // A parameter of 1 would give a zero-width counter; keep at least one bit.
    localparam int STABLE_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam int LOSS_W   = (LOSS_FILTER   > 1) ? $clog2(LOSS_FILTER)   : 1;
    localparam int HOLD_W   = (HOLD_CYCLES   > 1) ? $clog2(HOLD_CYCLES)   : 1;

    localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(STABLE_CYCLES - 1);
    localparam logic [LOSS_W-1:0]   LOSS_LAST   = LOSS_W'(LOSS_FILTER - 1);
    localparam logic [HOLD_W-1:0]   HOLD_LAST   = HOLD_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABILIZE = 2'd1,
        RUN       = 2'd2,
        HOLD_RST  = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] lock_sync;
    logic                   lock_s;

    state_t              state;
    logic                run_q;
    logic [STABLE_W-1:0] stable_cnt;
    logic [LOSS_W-1:0]   low_cnt;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [7:0]          lost_cnt;

    // LOCK comes from the CCC domain; only the last synchronizer stage is trusted.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            lock_sync <= '0;
        end else begin
            lock_sync <= {lock_sync[SYNC_STAGES-2:0], LOCK};
        end
    end

    assign lock_s = lock_sync[SYNC_STAGES-1];

    // run_q is loaded with the same decision as state, so outputs move on the STATE edge.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= WAIT_LOCK;
            run_q      <= 1'b0;
            stable_cnt <= '0;
            low_cnt    <= '0;
            hold_cnt   <= '0;
            lost_cnt   <= '0;
        end else begin
            case (state)
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state      <= STABILIZE;
                        stable_cnt <= '0;
                    end
                end
                STABILIZE: begin
                    if (!lock_s) begin
                        state <= WAIT_LOCK;
                    end else if (stable_cnt == STABLE_LAST) begin
                        state   <= RUN;
                        run_q   <= 1'b1;
                        low_cnt <= '0;
                    end else begin
                        stable_cnt <= stable_cnt + 1'b1;
                    end
                end
                RUN: begin
                    // A filtered loss wins over a coincident soft reset so it is still counted.
                    if (!lock_s && (low_cnt == LOSS_LAST)) begin
                        state    <= HOLD_RST;
                        run_q    <= 1'b0;
                        hold_cnt <= '0;
                        if (lost_cnt != 8'hFF) begin
                            lost_cnt <= lost_cnt + 8'd1;
                        end
                    end else if (SW_RST_REQ) begin
                        state    <= HOLD_RST;
                        run_q    <= 1'b0;
                        hold_cnt <= '0;
                    end else if (lock_s) begin
                        low_cnt <= '0;
                    end else begin
                        low_cnt <= low_cnt + 1'b1;
                    end
                end
                HOLD_RST: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state <= WAIT_LOCK;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign SYS_RESET_N   = run_q;
    assign READY         = run_q;
    assign LOCK_LOST_CNT = lost_cnt;
    assign STATE         = state;

endmodule
